// File: rtl/redstone_pkg.sv
// Shared types for the redstone tick fabric.
//   cmd_op_e    : host command opcodes (NOP/RUN/STEP/PAUSE), 2 bits
//   seq_state_e : tick sequencer state (IDLE/RUN/STEP), 2 bits
package redstone_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_RUN   = 2'd1,
        OP_STEP  = 2'd2,
        OP_PAUSE = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/tick_sequencer_if.sv
// Host command channel of the tick sequencer.
//   i_cmd_valid : host offers a command
//   o_cmd_ready : sequencer can accept a command this cycle
//   i_cmd_op    : opcode (cmd_op_e)
//   i_cmd_arg   : tick count for STEP
//
// Handshake: a command transfers on the rising i_clk edge where
// i_cmd_valid and o_cmd_ready are both high. While i_cmd_valid is high
// and o_cmd_ready is low the host keeps op/arg stable; nothing is dropped.
interface tick_sequencer_if #(
    parameter int ARG_W = 32
);
    import redstone_pkg::*;

    logic             i_cmd_valid;
    logic             o_cmd_ready;
    cmd_op_e          i_cmd_op;
    logic [ARG_W-1:0] i_cmd_arg;

    modport master (
        output i_cmd_valid,
        output i_cmd_op,
        output i_cmd_arg,
        input  o_cmd_ready
    );

    modport slave (
        input  i_cmd_valid,
        input  i_cmd_op,
        input  i_cmd_arg,
        output o_cmd_ready
    );

endinterface

// File: rtl/tick_divider.sv
// Phase counter that turns the system clock into a redstone tick strobe.
//   i_clk, i_rst : clock, async active-high reset
//   enable       : count this cycle (sequencer running)
//   clear        : restart the phase at zero (wins over enable)
//   divisor      : system clocks per tick; 0 behaves as 1
//   strobe       : registered one-cycle tick
//   due          : combinational, strobe will rise at the coming edge
module tick_divider #(
    parameter int DIV_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] divisor,
    output logic             strobe,
    output logic             due
);

    logic [DIV_W-1:0] phase_q;
    logic [DIV_W-1:0] last_phase;

    // Divisor 0 is treated as 1, so the last phase is 0 in both cases.
    assign last_phase = (divisor == '0) ? '0 : divisor - DIV_W'(1);

    // >= keeps the counter from running away if it is ever past the end.
    assign due = enable && !clear && (phase_q >= last_phase);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q <= '0;
            strobe  <= 1'b0;
        end else if (clear || !enable) begin
            phase_q <= '0;
            strobe  <= 1'b0;
        end else if (due) begin
            phase_q <= '0;
            strobe  <= 1'b1;
        end else begin
            phase_q <= phase_q + DIV_W'(1);
            strobe  <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_sequencer.sv
// Redstone game-tick sequencer: free-run, pause and step-N-ticks control
// of the tick strobe that advances the component fabric.
//   i_clk, i_rst  : system clock, async active-high reset
//   cmd           : host command channel (tick_sequencer_if.slave)
//   i_halt        : immediate stop from any state, kills a due tick
//   i_div_load    : load i_div as the divider (honoured in IDLE only)
//   i_div         : system clocks per tick
//   o_tick        : one-cycle tick strobe to the component fabric
//   o_tick_count  : ticks issued so far, wraps
//   o_state       : current seq_state_e
//   o_done        : one-cycle pulse when a STEP finishes
module tick_sequencer
    import redstone_pkg::*;
#(
    parameter int                DIV_W     = 32,
    parameter int                ARG_W     = 32,
    parameter int                CNT_W     = 64,
    parameter logic [DIV_W-1:0]  DIV_RESET = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    tick_sequencer_if.slave      cmd,
    input  logic                 i_halt,
    input  logic                 i_div_load,
    input  logic [DIV_W-1:0]     i_div,
    output logic                 o_tick,
    output logic [CNT_W-1:0]     o_tick_count,
    output logic [1:0]           o_state,
    output logic                 o_done
);

    seq_state_e       state_q, state_d;
    logic [ARG_W-1:0] remaining_q, remaining_d;
    logic [DIV_W-1:0] div_q;
    logic             done_d;

    logic    accept;
    logic    arg_nz;
    logic    start;
    logic    pause;
    logic    div_en;
    logic    div_clr;
    logic    tick_due;
    cmd_op_e op;

    assign op     = cmd.i_cmd_op;
    assign arg_nz = (cmd.i_cmd_arg != '0);

    // Commands are held off in STEP and while halt is asserted.
    assign cmd.o_cmd_ready = (state_q != ST_STEP) && !i_halt;
    assign accept          = cmd.i_cmd_valid && cmd.o_cmd_ready;

    // A run begins (phase restarts) on RUN from IDLE, or STEP N>0 from IDLE/RUN.
    assign start = accept &&
                   (((state_q == ST_IDLE) && ((op == OP_RUN) || ((op == OP_STEP) && arg_nz))) ||
                    ((state_q == ST_RUN) && (op == OP_STEP) && arg_nz));
    assign pause = accept && (state_q == ST_RUN) && (op == OP_PAUSE);

    // Enable depends only on the current state and controls, never on the
    // tick itself, so the last STEP tick still fires on its leaving edge.
    assign div_en  = (state_q != ST_IDLE) && !i_halt && !pause;
    assign div_clr = start || i_halt;

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .enable  (div_en),
        .clear   (div_clr),
        .divisor (div_q),
        .strobe  (o_tick),
        .due     (tick_due)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        if (i_halt) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == OP_RUN) begin
                            state_d = ST_RUN;
                        end else if (op == OP_STEP) begin
                            if (arg_nz) begin
                                state_d     = ST_STEP;
                                remaining_d = cmd.i_cmd_arg;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (op == OP_PAUSE) begin
                            state_d = ST_IDLE;
                        end else if ((op == OP_STEP) && arg_nz) begin
                            state_d     = ST_STEP;
                            remaining_d = cmd.i_cmd_arg;
                        end
                    end
                end
                ST_STEP: begin
                    if (tick_due) begin
                        remaining_d = remaining_q - ARG_W'(1);
                        if (remaining_q == ARG_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            o_done       <= 1'b0;
            o_tick_count <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            o_done      <= done_d;
            if (tick_due) begin
                o_tick_count <= o_tick_count + CNT_W'(1);
            end
        end
    end

    // A load together with an accepted RUN/STEP still lands here first,
    // so the new divisor governs that run.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q <= DIV_RESET;
        end else if ((state_q == ST_IDLE) && i_div_load) begin
            div_q <= i_div;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Self-checking bench for tick_sequencer. A second instance with a
// 2-bit tick counter exercises counter wrap.
module tb_tick_sequencer;
    import redstone_pkg::*;

    localparam int DIV_W  = 32;
    localparam int ARG_W  = 32;
    localparam int CNT_W  = 64;
    localparam int SCNT_W = 2;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    logic             i_halt;
    logic             i_div_load;
    logic [DIV_W-1:0] i_div;
    logic             o_tick;
    logic             o_done;
    logic [CNT_W-1:0] o_tick_count;
    logic [1:0]       o_state;

    logic              s_tick;
    logic              s_done;
    logic [SCNT_W-1:0] s_count;
    logic [1:0]        s_state;

    tick_sequencer_if #(.ARG_W(ARG_W)) cmd_if ();
    tick_sequencer_if #(.ARG_W(ARG_W)) s_if ();

    tick_sequencer #(
        .DIV_W (DIV_W), .ARG_W (ARG_W), .CNT_W (CNT_W), .DIV_RESET (2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .cmd          (cmd_if.slave),
        .i_halt       (i_halt),
        .i_div_load   (i_div_load),
        .i_div        (i_div),
        .o_tick       (o_tick),
        .o_tick_count (o_tick_count),
        .o_state      (o_state),
        .o_done       (o_done)
    );

    tick_sequencer #(
        .DIV_W (DIV_W), .ARG_W (ARG_W), .CNT_W (SCNT_W), .DIV_RESET (1)
    ) dut_small (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .cmd          (s_if.slave),
        .i_halt       (1'b0),
        .i_div_load   (1'b0),
        .i_div        ('0),
        .o_tick       (s_tick),
        .o_tick_count (s_count),
        .o_state      (s_state),
        .o_done       (s_done)
    );

    // ---------------- scoreboard ----------------
    int compared   = 0;
    int mismatched = 0;
    logic [CNT_W-1:0] exp_count;
    int model_div;
    // per-cycle expectation: {ready, state[1:0], done, tick}
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic offer(input cmd_op_e op, input logic [ARG_W-1:0] arg);
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd_op    = op;
        cmd_if.i_cmd_arg   = arg;
    endtask

    task automatic send(input cmd_op_e op, input logic [ARG_W-1:0] arg);
        offer(op, arg);
        cycle();
        cmd_if.i_cmd_valid = 1'b0;
        cmd_if.i_cmd_op    = OP_NOP;
    endtask

    task automatic load_div(input int d);
        i_div_load = 1'b1;
        i_div      = DIV_W'(d);
        cycle();
        i_div_load = 1'b0;
        model_div  = (d == 0) ? 1 : d;
    endtask

    // STEP of n ticks: tick every D cycles, done and IDLE with the n-th.
    task automatic step_case(input int n, input int d, input bit with_load);
        int dd;
        int total;
        logic [4:0] obs;
        if (with_load) begin
            i_div_load = 1'b1;
            i_div      = DIV_W'(d);
            model_div  = (d == 0) ? 1 : d;
        end
        dd    = model_div;
        total = n * dd;
        exp_q.delete();
        for (int c = 1; c <= total; c++) begin
            exp_q.push_back({(c == total), ((c == total) ? 2'd0 : 2'd2),
                             (c == total), ((c % dd) == 0)});
        end
        send(OP_STEP, ARG_W'(n));
        i_div_load = 1'b0;
        check("step ready after accept", 64'(cmd_if.o_cmd_ready), 64'(0));
        for (int c = 1; c <= total; c++) begin
            cycle();
            obs = {cmd_if.o_cmd_ready, o_state, o_done, o_tick};
            check($sformatf("step n%0d d%0d c%0d", n, dd, c), 64'(obs), 64'(exp_q.pop_front()));
        end
        exp_count += CNT_W'(n);
        check($sformatf("step n%0d count", n), o_tick_count, exp_count);
    endtask

    // Observes cycles first..last of a run at the model divisor.
    task automatic watch_run(input int first, input int last, input string tag);
        for (int c = first; c <= last; c++) begin
            cycle();
            check($sformatf("%s tick c%0d", tag, c), 64'(o_tick), 64'((c % model_div) == 0));
            if ((c % model_div) == 0) exp_count += CNT_W'(1);
        end
        check($sformatf("%s state", tag), 64'(o_state), 64'(1));
        check($sformatf("%s count", tag), o_tick_count, exp_count);
    endtask

    task automatic do_pause(input string tag);
        send(OP_PAUSE, '0);
        check($sformatf("%s pause tick", tag), 64'(o_tick), 64'(0));
        check($sformatf("%s pause state", tag), 64'(o_state), 64'(0));
        check($sformatf("%s pause count", tag), o_tick_count, exp_count);
        cycle();
        check($sformatf("%s after pause tick", tag), 64'(o_tick), 64'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        i_rst              = 1'b1;
        i_halt             = 1'b0;
        i_div_load         = 1'b0;
        i_div              = '0;
        cmd_if.i_cmd_valid = 1'b0;
        cmd_if.i_cmd_op    = OP_NOP;
        cmd_if.i_cmd_arg   = '0;
        s_if.i_cmd_valid   = 1'b0;
        s_if.i_cmd_op      = OP_NOP;
        s_if.i_cmd_arg     = '0;
        exp_count          = '0;
        model_div          = 2;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // reset values
        check("reset state", 64'(o_state), 64'(0));
        check("reset tick", 64'(o_tick), 64'(0));
        check("reset done", 64'(o_done), 64'(0));
        check("reset count", o_tick_count, 64'(0));
        check("reset ready", 64'(cmd_if.o_cmd_ready), 64'(1));
        cycle();

        // STEP 3 at the reset divider of 2
        step_case(3, 2, 1'b0);

        // divider 0 behaves as 1: continuous ticks, stop on PAUSE
        load_div(0);
        send(OP_RUN, '0);
        watch_run(1, 5, "run d1");
        do_pause("run d1");

        // STEP 0: single done pulse, no tick, stays IDLE
        send(OP_STEP, '0);
        check("step0 done", 64'(o_done), 64'(1));
        check("step0 tick", 64'(o_tick), 64'(0));
        check("step0 state", 64'(o_state), 64'(0));
        for (int c = 1; c <= 3; c++) begin
            cycle();
            check($sformatf("step0 done c%0d", c), 64'(o_done), 64'(0));
            check($sformatf("step0 tick c%0d", c), 64'(o_tick), 64'(0));
        end
        check("step0 count", o_tick_count, exp_count);

        // STEP 4 at D=3, halt on the edge of the second tick
        load_div(3);
        send(OP_STEP, ARG_W'(4));
        for (int c = 1; c <= 5; c++) begin
            cycle();
            check($sformatf("halt tick c%0d", c), 64'(o_tick), 64'(c == 3));
        end
        exp_count += CNT_W'(1);
        i_halt = 1'b1;
        offer(OP_RUN, '0);
        cycle();
        check("halt tick", 64'(o_tick), 64'(0));
        check("halt done", 64'(o_done), 64'(0));
        check("halt state", 64'(o_state), 64'(0));
        check("halt ready", 64'(cmd_if.o_cmd_ready), 64'(0));
        check("halt count", o_tick_count, exp_count);
        cycle();
        check("halt blocks cmd", 64'(o_state), 64'(0));
        i_halt             = 1'b0;
        cmd_if.i_cmd_valid = 1'b0;
        cmd_if.i_cmd_op    = OP_NOP;
        #1;
        check("halt release ready", 64'(cmd_if.o_cmd_ready), 64'(1));
        cycle();
        check("halt idle tick", 64'(o_tick), 64'(0));

        // divider load ignored while running, honoured in IDLE
        send(OP_RUN, '0);
        watch_run(1, 6, "run d3a");
        i_div_load = 1'b1;
        i_div      = DIV_W'(5);
        watch_run(7, 7, "run d3 load");
        i_div_load = 1'b0;
        watch_run(8, 12, "run d3b");
        do_pause("run d3");
        load_div(5);
        send(OP_RUN, '0);
        watch_run(1, 10, "run d5");
        do_pause("run d5");

        // randomized STEPs, divider loaded together with the command
        for (int i = 0; i < 4; i++) begin
            step_case(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'b1);
            cycle();
        end

        // counter wrap on the 2-bit instance (divider 1)
        s_if.i_cmd_valid = 1'b1;
        s_if.i_cmd_op    = OP_RUN;
        cycle();
        s_if.i_cmd_valid = 1'b0;
        s_if.i_cmd_op    = OP_NOP;
        for (int c = 1; c <= 5; c++) begin
            cycle();
            check($sformatf("wrap tick c%0d", c), 64'(s_tick), 64'(1));
            check($sformatf("wrap count c%0d", c), 64'(s_count), 64'(c % (1 << SCNT_W)));
        end

        // async reset in the middle of a run, no clock edge in between
        load_div(1);
        send(OP_RUN, '0);
        repeat (3) cycle();
        check("pre-reset tick", 64'(o_tick), 64'(1));
        #2 i_rst = 1'b1;
        #1;
        check("async rst tick", 64'(o_tick), 64'(0));
        check("async rst state", 64'(o_state), 64'(0));
        check("async rst done", 64'(o_done), 64'(0));
        check("async rst count", o_tick_count, 64'(0));
        check("async rst ready", 64'(cmd_if.o_cmd_ready), 64'(1));
        check("async rst small", 64'(s_count), 64'(0));
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        cycle();
        check("post-reset tick", 64'(o_tick), 64'(0));
        check("post-reset done", 64'(o_done), 64'(0));

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
